game_state_tx: RTL and testbench
================================

Name: game_state_tx

Overview:
- Transmit side of the inter-board game-state link.
- Once per video frame, snapshots the local player's game outputs and serialises them into a fixed 11-byte framed packet with checksum.
- Drives a byte-wide valid/ready stream into the UART transmitter, so the server or peer FPGAs can mirror this player.
- Sits between game_logic outputs and the serial TX block.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- FRAME_DIV, 1, send one packet every FRAME_DIV frames (1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- vsync  in  1  frame strobe; asynchronous to nothing (same clock domain), sampled each cycle
- tx_enable  in  1  permits new packets to start
- local_player_ID  in  2  this board's player ID
- game_state  in  3  current game state
- player_state  in  4  held-object/action code
- player_direction  in  2  facing direction
- player_loc_x  in  9  player x pixel
- player_loc_y  in  9  player y pixel
- point_total  in  10  team score
- team_name  in  3x8  ASCII letters [2]..[0]
- tx_data  out  8  byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte this cycle
- busy  out  1  packet in flight
- seq  out  4  sequence number of next packet
- drop_count  out  8  saturating count of skipped frames

Behaviour:
- Reset: tx_data=0, tx_valid=0, busy=0, seq=0, drop_count=0, frame divider=0, FSM=IDLE, vsync history register=0.
- Reset mid-packet aborts it immediately; no partial resume.
- Frame tick: vsync_q==1 && vsync==0, where vsync_q is vsync registered one cycle.
- Divider counts ticks 0..FRAME_DIV-1; a send request fires on the tick where the divider wraps to 0.
- With FRAME_DIV=1, every tick is a request.
- Request while IDLE and tx_enable=1:
  - On that clock edge, snapshot all inputs into a packet register.
  - Go to SEND, byte index 0.
  - busy=1, tx_valid=1, tx_data=SYNC_BYTE on the next cycle.
- Request while IDLE and tx_enable=0: ignored, not counted.
- Request while busy: drop_count increments, saturating at 255; the packet in flight is unaffected.
- Packet bytes:
  - B0: SYNC_BYTE
  - B1: {seq, local_player_ID, player_direction}
  - B2: {player_state, 1'b0, game_state}
  - B3: player_loc_x[7:0]
  - B4: player_loc_y[7:0]
  - B5: {2'b00, point_total[9:8], 2'b00, player_loc_y[8], player_loc_x[8]}
  - B6: point_total[7:0]
  - B7: team_name[2]
  - B8: team_name[1]
  - B9: team_name[0]
  - B10: checksum = XOR of B1..B9
- Checksum is accumulated as bytes are accepted and presented in state CSUM.
- Handshake rules:
  - tx_valid stays high and tx_data stays stable until a cycle with tx_valid&&tx_ready.
  - After each transfer, the next byte is presented the following cycle; no bubble.
  - Bytes never repeat or skip.
- tx_ready high while tx_valid is low has no effect.
- Transfer of B10:
  - tx_valid=0 and busy=0 next cycle; FSM returns to IDLE.
  - seq increments mod 16.
- A request on the same cycle B10 transfers counts as a drop, because busy is still 1.
- Deasserting tx_enable mid-packet does not stop it; it only blocks future starts.
- Input changes after the snapshot do not alter the packet in flight.
- FSM states:
  - IDLE: waiting for a request.
  - SEND: B0..B9, 4-bit byte index.
  - CSUM: B10.
- Minimum packet duration is 11 cycles with tx_ready held high.

Test Plan:
- Tick and packet contents.
  - Stimulus: reset; tx_ready=1; ID=2, dir=1, player_state=4'h3, game_state=2, x=9'h105, y=9'h0C8, points=10'h2A7, team="KYE" (team_name[2]=0x4B, [1]=0x59, [0]=0x45); one vsync 1->0.
  - Required: bytes A5,09,32,05,C8,21,A7,4B,59,45, then checksum (XOR B1..B9) recomputed and compared.
  - Required: tx_valid is high for exactly 11 consecutive cycles starting 1 cycle after the tick; seq=1 afterwards.
- Backpressure.
  - Stimulus: tx_ready toggled randomly with 30% high.
  - Required: tx_data is stable whenever valid&&!ready; the received stream matches the snapshot; checksum is correct.
- Overrun.
  - Stimulus: tx_ready=0 held; issue 3 ticks.
  - Required: drop_count=2; the first packet completes correctly once ready rises.
  - Stimulus: hold tx_ready=0 across 300 ticks.
  - Required: drop_count saturates at 255.
- Snapshot isolation.
  - Stimulus: change player_loc_x to 0 during transmission of B2.
  - Required: B3 is still 05; the next packet carries 00.
- FRAME_DIV=3 and enable.
  - Stimulus: 9 ticks.
  - Required: packets start on ticks 3, 6 and 9 only (counting ticks from 1); seq=3 afterwards.
  - Stimulus: tx_enable=0 during 3 further ticks.
  - Required: no packet, drop_count unchanged.
- Reset mid-packet and seq wrap.
  - Stimulus: assert reset during B5.
  - Required: next cycle tx_valid=0, busy=0, seq=0.
  - Stimulus: send 17 packets.
  - Required: B1[7:4] of the 17th packet is 0; seq=1 afterwards.

Source files
------------

// File: rtl/game_state_tx_if.sv
// Byte-wide valid/ready stream between the game-state packetiser and the
// UART transmitter.
//   tx_data  : byte presented by the master
//   tx_valid : tx_data holds a byte to transfer
//   tx_ready : slave accepts the byte this cycle (transfer = valid && ready)
interface game_state_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/game_state_tx.sv
// game_state_tx: transmit side of the inter-board game-state link.
// Once every FRAME_DIV frames (falling edge of vsync) the local player's game
// outputs are snapshotted and sent as an 11-byte packet:
//   B0 sync, B1..B9 payload, B10 = XOR of B1..B9.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   vsync               : frame strobe (same clock domain)
//   tx_enable           : allows new packets to start
//   local_player_ID .. team_name : game outputs to snapshot
//   tx (master)         : byte stream to the UART (tx_data/tx_valid/tx_ready)
//   busy                : packet in flight
//   seq                 : sequence number of the next packet
//   drop_count          : saturating count of requests lost while busy
module game_state_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FRAME_DIV = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vsync,
  input  logic                tx_enable,
  input  logic [1:0]          local_player_ID,
  input  logic [2:0]          game_state,
  input  logic [3:0]          player_state,
  input  logic [1:0]          player_direction,
  input  logic [8:0]          player_loc_x,
  input  logic [8:0]          player_loc_y,
  input  logic [9:0]          point_total,
  input  logic [2:0][7:0]     team_name,
  game_state_tx_if.master     tx,
  output logic                busy,
  output logic [3:0]          seq,
  output logic [7:0]          drop_count
);

  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t      state;
  logic        vsync_q;
  logic [7:0]  div_cnt;
  logic [3:0]  byte_idx;
  logic [7:0]  csum;
  // Snapshot of B1..B9, B1 in the top byte; shifted left as bytes go out.
  logic [71:0] pkt_sr;

  logic frame_tick;
  logic send_req;
  logic xfer;

  assign frame_tick = vsync_q && !vsync;
  assign send_req   = frame_tick && (div_cnt == DIV_LAST);
  assign xfer       = tx.tx_valid && tx.tx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      div_cnt     <= '0;
      byte_idx    <= '0;
      csum        <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      seq         <= '0;
      drop_count  <= '0;
    end else begin
      vsync_q <= vsync;

      if (frame_tick)
        div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;

      // busy is still high on the cycle B10 transfers, so a request there
      // is counted as a drop as well.
      if (send_req && busy && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (send_req && tx_enable) begin
            pkt_sr <= {seq, local_player_ID, player_direction,
                       player_state, 1'b0, game_state,
                       player_loc_x[7:0],
                       player_loc_y[7:0],
                       2'b00, point_total[9:8], 2'b00, player_loc_y[8], player_loc_x[8],
                       point_total[7:0],
                       team_name};
            tx.tx_data  <= SYNC_BYTE;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
            byte_idx    <= '0;
            csum        <= '0;
            state       <= SEND;
          end
        end

        SEND: begin
          if (xfer) begin
            // The sync byte is excluded from the checksum.
            if (byte_idx != 4'd0)
              csum <= csum ^ tx.tx_data;
            if (byte_idx == 4'd9) begin
              tx.tx_data <= csum ^ tx.tx_data;
              state      <= CSUM;
            end else begin
              tx.tx_data <= pkt_sr[71:64];
              pkt_sr     <= pkt_sr << 8;
              byte_idx   <= byte_idx + 4'd1;
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            seq         <= seq + 4'd1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_tx.sv
// Directed bench for game_state_tx: two instances (FRAME_DIV=1 and 3) share
// the game inputs; expected bytes come from hand values and a packet builder.
module tb_game_state_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            vsync;
  logic            en1, en3;
  logic [1:0]      pid;
  logic [2:0]      gstate;
  logic [3:0]      pstate;
  logic [1:0]      dir;
  logic [8:0]      px, py;
  logic [9:0]      pts;
  logic [2:0][7:0] team;

  logic       busy1, busy3;
  logic [3:0] seq1, seq3;
  logic [7:0] drop1, drop3;

  game_state_tx_if if1();
  game_state_tx_if if3();

  game_state_tx #(.SYNC_BYTE(8'hA5), .FRAME_DIV(1)) dut1 (
    .clock(clk), .reset(reset), .vsync(vsync), .tx_enable(en1),
    .local_player_ID(pid), .game_state(gstate), .player_state(pstate),
    .player_direction(dir), .player_loc_x(px), .player_loc_y(py),
    .point_total(pts), .team_name(team), .tx(if1),
    .busy(busy1), .seq(seq1), .drop_count(drop1)
  );

  game_state_tx #(.SYNC_BYTE(8'hA5), .FRAME_DIV(3)) dut3 (
    .clock(clk), .reset(reset), .vsync(vsync), .tx_enable(en3),
    .local_player_ID(pid), .game_state(gstate), .player_state(pstate),
    .player_direction(dir), .player_loc_x(px), .player_loc_y(py),
    .point_total(pts), .team_name(team), .tx(if3),
    .busy(busy3), .seq(seq3), .drop_count(drop3)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0][7:0] build_pkt(input logic [3:0] s);
    logic [10:0][7:0] p;
    p[0]  = 8'hA5;
    p[1]  = {s, pid, dir};
    p[2]  = {pstate, 1'b0, gstate};
    p[3]  = px[7:0];
    p[4]  = py[7:0];
    p[5]  = {2'b00, pts[9:8], 2'b00, py[8], px[8]};
    p[6]  = pts[7:0];
    p[7]  = team[2];
    p[8]  = team[1];
    p[9]  = team[0];
    p[10] = 8'h00;
    for (int i = 1; i <= 9; i++) p[10] = p[10] ^ p[i];
    return p;
  endfunction

  task automatic cmp_pkt(input string name, input logic [10:0][7:0] got,
                         input logic [10:0][7:0] exp);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s_B%0d", name, i), 32'(got[i]), 32'(exp[i]));
  endtask

  // Called at a negedge; returns at the negedge after the tick edge.
  task automatic do_tick();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Expects valid on 11 consecutive cycles with tx_ready held high;
  // optionally clears player_loc_x while byte chg_at is presented.
  task automatic watch_pkt(input string name, input int chg_at,
                           output logic [10:0][7:0] b);
    b = '0;
    if1.tx_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_valid%0d", name, i), 32'(if1.tx_valid), 32'd1);
      b[i] = if1.tx_data;
      if (i == chg_at) px = 9'h000;
      @(negedge clk);
    end
    check({name, "_valid_end"}, 32'(if1.tx_valid), 32'd0);
    check({name, "_busy_end"}, 32'(busy1), 32'd0);
  endtask

  // Collects one packet from dut1, optionally with random backpressure,
  // checking that a stalled byte holds until it is accepted.
  task automatic recv_pkt(input bit rnd, output logic [10:0][7:0] b);
    int n;
    bit stall;
    bit rdy;
    logic [7:0] pd;
    n = 0; stall = 1'b0; pd = '0; b = '0;
    for (int c = 0; c < 4000 && n < 11; c++) begin
      if (stall) begin
        check("stall_data", 32'(if1.tx_data), 32'(pd));
        check("stall_valid", 32'(if1.tx_valid), 32'd1);
      end
      rdy = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if1.tx_ready = rdy;
      if (if1.tx_valid && rdy) begin
        b[n] = if1.tx_data;
        n++;
      end
      stall = if1.tx_valid && !rdy;
      pd = if1.tx_data;
      @(negedge clk);
    end
    check("recv_count", 32'(n), 32'd11);
  endtask

  logic [10:0][7:0] got, exp;
  logic [7:0] x;

  initial begin
    reset = 1'b1; vsync = 1'b0; en1 = 1'b1; en3 = 1'b0;
    if1.tx_ready = 1'b0; if3.tx_ready = 1'b1;
    pid = 2'd2; dir = 2'd1; pstate = 4'h3; gstate = 3'd2;
    px = 9'h105; py = 9'h0C8; pts = 10'h2A7;
    team = {8'h4B, 8'h59, 8'h45};
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid", 32'(if1.tx_valid), 32'd0);
    check("rst_data", 32'(if1.tx_data), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_seq", 32'(seq1), 32'd0);
    check("rst_drop", 32'(drop1), 32'd0);

    // Tick and hand-computed packet contents
    if1.tx_ready = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    check("t1_not_early", 32'(if1.tx_valid), 32'd0);
    @(negedge clk);
    exp = {8'h00, 8'h45, 8'h59, 8'h4B, 8'hA7, 8'h21, 8'hC8, 8'h05, 8'h32, 8'h09, 8'hA5};
    x = 8'h00;
    for (int i = 1; i <= 9; i++) x = x ^ exp[i];
    exp[10] = x;
    watch_pkt("t1", -1, got);
    cmp_pkt("t1", got, exp);
    check("t1_seq", 32'(seq1), 32'd1);

    // Backpressure with new contents
    pid = 2'd1; dir = 2'd3; pstate = 4'hA; gstate = 3'd5;
    px = 9'h1F0; py = 9'h13C; pts = 10'h155;
    team = {8'h41, 8'h42, 8'h43};
    exp = build_pkt(4'd1);
    do_tick();
    recv_pkt(1'b1, got);
    cmp_pkt("bp", got, exp);
    check("bp_seq", 32'(seq1), 32'd2);

    // Overrun: 3 ticks with the UART stalled
    if1.tx_ready = 1'b0;
    exp = build_pkt(4'd2);
    do_tick();
    do_tick();
    do_tick();
    check("ovr_drop2", 32'(drop1), 32'd2);
    recv_pkt(1'b0, got);
    cmp_pkt("ovr", got, exp);

    // Saturation of drop_count
    if1.tx_ready = 1'b0;
    exp = build_pkt(4'd3);
    do_tick();
    for (int i = 0; i < 300; i++) do_tick();
    check("sat_drop", 32'(drop1), 32'd255);
    recv_pkt(1'b0, got);
    cmp_pkt("sat", got, exp);
    check("sat_drop_hold", 32'(drop1), 32'd255);

    // Snapshot isolation
    pid = 2'd2; dir = 2'd1; pstate = 4'h3; gstate = 3'd2;
    px = 9'h105; py = 9'h0C8; pts = 10'h2A7;
    team = {8'h4B, 8'h59, 8'h45};
    exp = build_pkt(4'd4);
    do_tick();
    watch_pkt("iso", 2, got);
    check("iso_B3", 32'(got[3]), 32'h05);
    cmp_pkt("iso", got, exp);
    exp = build_pkt(4'd5);
    do_tick();
    recv_pkt(1'b0, got);
    check("iso_next_B3", 32'(got[3]), 32'h00);
    cmp_pkt("iso_next", got, exp);

    // Reset in the middle of a packet
    if1.tx_ready = 1'b1;
    do_tick();
    wait_cycles(5);
    check("mid_at_B5", 32'(if1.tx_data), 32'(exp[5]));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_valid", 32'(if1.tx_valid), 32'd0);
    check("mid_busy", 32'(busy1), 32'd0);
    check("mid_seq", 32'(seq1), 32'd0);
    @(negedge clk);

    // Sequence wrap over 17 packets
    for (int k = 0; k < 17; k++) begin
      exp = build_pkt(4'(k));
      do_tick();
      recv_pkt(1'b0, got);
      if (k == 16) begin
        check("wrap_seqfield", 32'(got[1][7:4]), 32'd0);
        cmp_pkt("wrap", got, exp);
      end
    end
    check("wrap_seq", 32'(seq1), 32'd1);

    // FRAME_DIV=3 instance
    do_reset();
    @(negedge clk);
    en3 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      do_tick();
      check($sformatf("div3_tick%0d", k), 32'(if3.tx_valid), (k % 3 == 0) ? 32'd1 : 32'd0);
      wait_cycles(13);
    end
    check("div3_seq", 32'(seq3), 32'd3);
    check("div3_drop", 32'(drop3), 32'd0);
    en3 = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      do_tick();
      check($sformatf("div3_dis%0d", k), 32'(if3.tx_valid), 32'd0);
      wait_cycles(13);
    end
    check("div3_dis_drop", 32'(drop3), 32'd0);
    check("div3_dis_seq", 32'(seq3), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
